// File: rtl/instruction_dispatcher_pkg.sv
// Shared sizing, serializing-opcode constants and state encodings for the
// instruction dispatcher and its per-processor trackers.
package instruction_dispatcher_pkg;

   localparam int REGISTER_AMOUNT = 32;
   localparam int INSTR_WIDTH     = 32;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {EMPTY, CHECK, BOOT} disp_state_t;
   typedef enum logic [1:0] {FREE, STARTING, RUNNING} trk_state_t;

   // Control-flow instructions must see both processors drained and coherent.
   function automatic logic is_serializing(input logic [6:0] op);
      return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
   endfunction

endpackage

// File: rtl/instruction_dispatcher_proc_tracker.sv
// Tracks one processor's lifecycle: booted, observed busy, then idle again.
module proc_tracker
   import instruction_dispatcher_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       boot,
   input  logic       idle,
   output trk_state_t state
);

   trk_state_t state_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FREE;
      else        state <= state_nx;
   end

   // STARTING waits for the processor to drop idle so a stale idle flag
   // sampled right after boot is not mistaken for completion.
   always_comb begin
      state_nx = state;
      case (state)
         FREE:     if (boot)  state_nx = STARTING;
         STARTING: if (!idle) state_nx = RUNNING;
         RUNNING:  if (idle)  state_nx = FREE;
         default:             state_nx = FREE;
      endcase
   end

endmodule

// File: rtl/instruction_dispatcher.sv
// Holds one fetched instruction, checks register hazards and processor
// availability, then issues it to one of two processors with a boot pulse.
module instruction_dispatcher #(
   parameter int REGISTER_AMOUNT = instruction_dispatcher_pkg::REGISTER_AMOUNT,
   parameter int INSTR_WIDTH     = instruction_dispatcher_pkg::INSTR_WIDTH,
   parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT)
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     instr_valid,
   input  logic [INSTR_WIDTH-1:0]   instr_data,
   output logic                     instr_ready,
   input  logic                     processor_idle_1,
   input  logic                     processor_idle_2,
   input  logic [0:REGISTER_AMOUNT-1] processing_register_table,
   input  logic                     synchronized_processors,
   output logic                     boot_renew_register_1,
   output logic                     boot_renew_register_2,
   output logic [REG_CTN_WIDTH-1:0] register_num,
   output logic [INSTR_WIDTH-1:0]   dispatch_instr_1,
   output logic [INSTR_WIDTH-1:0]   dispatch_instr_2
);
   import instruction_dispatcher_pkg::*;

   disp_state_t                state, state_nx;
   trk_state_t                 trk_1, trk_2;
   logic [INSTR_WIDTH-1:0]     hold_instr;
   logic [REGISTER_AMOUNT-1:0] recent_rd, rd_onehot;
   logic [4:0]                 rd, rs1, rs2;
   logic                       hazard, elig_1, elig_2, ser_ok, go;

   assign rd  = hold_instr[11:7];
   assign rs1 = hold_instr[19:15];
   assign rs2 = hold_instr[24:20];

   assign instr_ready = rst_n && (state == EMPTY);

   // recent_rd bridges the cycle between a boot and the table reflecting it.
   always_comb begin
      hazard = 1'b0;
      if (rd  != 5'd0 && (processing_register_table[rd]  || recent_rd[rd]))  hazard = 1'b1;
      if (rs1 != 5'd0 && (processing_register_table[rs1] || recent_rd[rs1])) hazard = 1'b1;
      if (rs2 != 5'd0 && (processing_register_table[rs2] || recent_rd[rs2])) hazard = 1'b1;
   end

   assign elig_1 = (trk_1 == FREE) && processor_idle_1;
   assign elig_2 = (trk_2 == FREE) && processor_idle_2;
   assign ser_ok = !is_serializing(hold_instr[6:0]) ||
                   (synchronized_processors && trk_1 == FREE && trk_2 == FREE);
   assign go     = !hazard && ser_ok && (elig_1 || elig_2);

   always_comb begin
      rd_onehot = '0;
      rd_onehot[register_num] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         EMPTY:   if (instr_valid) state_nx = CHECK;
         CHECK:   if (go)          state_nx = BOOT;
         BOOT:                     state_nx = EMPTY;
         default:                  state_nx = EMPTY;
      endcase
   end

   // Boot outputs are registered on the CHECK->BOOT edge so the pulse
   // coincides exactly with the BOOT state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_instr            <= '0;
         recent_rd             <= '0;
         boot_renew_register_1 <= 1'b0;
         boot_renew_register_2 <= 1'b0;
         register_num          <= '0;
         dispatch_instr_1      <= '0;
         dispatch_instr_2      <= '0;
      end else begin
         boot_renew_register_1 <= 1'b0;
         boot_renew_register_2 <= 1'b0;
         recent_rd             <= '0;
         if (state == EMPTY && instr_valid) hold_instr <= instr_data;
         if (state == CHECK && go) begin
            boot_renew_register_1 <= elig_1;
            boot_renew_register_2 <= !elig_1;
            register_num          <= REG_CTN_WIDTH'(rd);
            if (elig_1) dispatch_instr_1 <= hold_instr;
            else        dispatch_instr_2 <= hold_instr;
         end
         if (boot_renew_register_1 || boot_renew_register_2) recent_rd <= rd_onehot;
      end
   end

   proc_tracker u_trk_1 (
      .clk   (clk),
      .rst_n (rst_n),
      .boot  (boot_renew_register_1),
      .idle  (processor_idle_1),
      .state (trk_1)
   );

   proc_tracker u_trk_2 (
      .clk   (clk),
      .rst_n (rst_n),
      .boot  (boot_renew_register_2),
      .idle  (processor_idle_2),
      .state (trk_2)
   );

endmodule

// File: doc/instruction_dispatcher.md
INSTRUCTION_DISPATCHER -- requirements
Module: instruction_dispatcher

Interface
REQ-001 Parameter REGISTER_AMOUNT, default 32, is the architectural register count.
REQ-002 Parameter INSTR_WIDTH, default 32, is the instruction word width.
REQ-003 Parameter REG_CTN_WIDTH, default $clog2(REGISTER_AMOUNT), is the register index width.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port instr_valid, input, 1: upstream fetch queue presents an instruction.
REQ-007 Port instr_data, input, INSTR_WIDTH: RISC-V word; rd=[11:7], rs1=[19:15], rs2=[24:20], opcode=[6:0].
REQ-008 Port instr_ready, output, 1: the instruction is accepted when instr_valid and instr_ready are both 1.
REQ-009 Port processor_idle_1 / processor_idle_2, input, 1 each: per-processor idle flags.
REQ-010 Port processing_register_table, input, [0:REGISTER_AMOUNT-1]: registers with an update in flight.
REQ-011 Port synchronized_processors, input, 1: both processors' register copies are coherent.
REQ-012 Port boot_renew_register_1 / boot_renew_register_2, output, 1 each: one-cycle issue pulse to processor 1 / 2.
REQ-013 Port register_num, output, REG_CTN_WIDTH: rd of the issuing instruction, valid while a boot pulse is high.
REQ-014 Port dispatch_instr_1 / dispatch_instr_2, output, INSTR_WIDTH each: instruction word last issued to each processor, held until the next issue.

Function
REQ-015 FSM states: EMPTY, CHECK, BOOT; the holding register is loaded on an EMPTY-state handshake, then EMPTY->CHECK.
REQ-016 instr_ready SHALL be 1 only in EMPTY.
REQ-017 A hazard exists if any used index (rd, rs1, rs2, ignoring index 0) is set in processing_register_table or in the internal recent_rd mask.
REQ-018 recent_rd SHALL hold the rd of the previous issue for exactly one cycle after its boot pulse, covering the one-cycle latency before the table updates.
REQ-019 Serializing opcodes are 1100011, 1101111 and 1100111; these issue only when synchronized_processors=1 and both trackers are FREE.
REQ-020 CHECK->BOOT when there is no hazard and a tracker is FREE with its processor_idle=1.
REQ-021 Processor 1 SHALL win when both processors are eligible.
REQ-022 BOOT SHALL last one cycle, with exactly one boot pulse high, register_num=rd and dispatch_instr_x loaded; then BOOT->EMPTY.
REQ-023 Both boot outputs SHALL never be high in the same cycle.
REQ-024 Each processor has a tracker with states FREE, STARTING and RUNNING.
REQ-025 Tracker transitions: FREE->STARTING on its boot; STARTING->RUNNING when idle=0; RUNNING->FREE when idle=1.
REQ-026 If no processor is eligible, stay in CHECK indefinitely with outputs held and no pulse.
REQ-027 rd=0 instructions SHALL still issue, with register_num=0.

Reset
REQ-028 While rst_n=0: FSM=EMPTY, both trackers FREE, recent_rd=0, holding register=0.
REQ-029 While rst_n=0: boot outputs=0, register_num=0, dispatch_instr_1/2=0, instr_ready=0.
REQ-030 instr_ready SHALL rise in the first cycle after deassertion.
REQ-031 A reset in CHECK or BOOT SHALL discard the held instruction, and any boot pulse SHALL drop immediately.

Structure
REQ-032 The shared package holds REGISTER_AMOUNT, INSTR_WIDTH, the serializing-opcode constants, and the FSM and tracker state enums.
REQ-033 The per-processor tracker SHALL be a sub-module, proc_tracker, instantiated twice.

Verification
REQ-034 Reset, then instr_data=0x00500093 (addi x1,x0,5) valid, both idle=1, table=0:
- boot_renew_register_1 pulses 2 cycles after acceptance, with register_num=1 and dispatch_instr_1=0x00500093.
REQ-035 Back-to-back addi x2 then add x3,x2,x2, table bit 2 set one cycle after the first boot:
- the second instruction waits until bit 2 clears, then boots with register_num=3.
REQ-036 Tracker 1 in RUNNING, processor_idle_2=1, independent instruction:
- boot_renew_register_2 pulses; boot_renew_register_1 stays 0.
REQ-037 beq (opcode 1100011) with synchronized_processors=0:
- the instruction waits in CHECK and issues one cycle after synchronized_processors rises and both trackers are FREE.
REQ-038 rst_n pulled low during BOOT:
- the pulse drops asynchronously; after release instr_ready=1, and the dropped instruction never issues.
